// File: rtl/bus_sizer_pkg.sv
// bus_sizer_pkg: termination, size and port-width encodings plus the FSM state
// type shared by the 68040 dynamic bus sizer.
package bus_sizer_pkg;

    // {TACKn, TEAn} as driven by the Amiga-side target
    typedef enum logic [1:0] {
        TERM_RETRY  = 2'b00,
        TERM_NORMAL = 2'b01,
        TERM_ERROR  = 2'b10,
        TERM_WAIT   = 2'b11
    } term_e;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    localparam logic [1:0] PS_32     = 2'b00;
    localparam logic [1:0] PS_16     = 2'b01;
    localparam logic [1:0] PS_8      = 2'b10;
    localparam logic [1:0] PS_32_ALT = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, DONE} state_e;

    // A_PORT advance per sub-cycle; a 32-bit port wraps straight back to the start
    function automatic logic [1:0] addr_step(input logic [1:0] ps);
        logic [1:0] step;
        case (ps)
            PS_16:   step = 2'd2;
            PS_8:    step = 2'd1;
            default: step = 2'd0;
        endcase
        return step;
    endfunction

    // Index of the final sub-cycle, i.e. max(1, bytes/portbytes) - 1
    function automatic logic [1:0] last_sub(input logic [1:0] siz, input logic [1:0] ps);
        logic [1:0] last;
        last = 2'd0;
        case (ps)
            PS_16: if (siz == SIZ_LONG || siz == SIZ_LINE) last = 2'd1;
            PS_8: begin
                case (siz)
                    SIZ_WORD:           last = 2'd1;
                    SIZ_LONG, SIZ_LINE: last = 2'd3;
                    default:            last = 2'd0;
                endcase
            end
            default: last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/bus_lane_steer.sv
// bus_lane_steer: combinational byte-lane steering between the CPU lanes and a
// 32/16/8-bit port that sits on the upper data lanes.
module bus_lane_steer
    import bus_sizer_pkg::*;
(
    input  logic [1:0]  i_portsize,
    input  logic [1:0]  i_a_port,
    input  logic        i_rnw,
    input  logic [31:0] i_d_cpu,
    input  logic [31:0] i_d_port,
    output logic [3:0]  o_rd_lane_en,
    output logic [31:0] o_rd_data,
    output logic [31:0] o_wr_data
);

    logic [1:0]  w_off;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_port_mask;
    logic [31:0] w_cpu_shifted;

    // Offset is A_PORT aligned to the port width, so a 32-bit port is never shifted
    // and an odd byte on a 16-bit port rides on the port's second lane.
    always_comb begin
        w_off       = 2'd0;
        w_lane_mask = 4'b1111;
        w_port_mask = 32'hFFFF_FFFF;
        case (i_portsize)
            PS_16: begin
                w_off       = {i_a_port[1], 1'b0};
                w_lane_mask = 4'b0011;
                w_port_mask = 32'hFFFF_0000;
            end
            PS_8: begin
                w_off       = i_a_port;
                w_lane_mask = 4'b0001;
                w_port_mask = 32'hFF00_0000;
            end
            default: ;
        endcase
    end

    assign w_cpu_shifted = i_d_cpu << {w_off, 3'b000};

    // Lane enable bit n selects address lane n, i.e. bits [31-8n -: 8]
    assign o_rd_lane_en = i_rnw ? (w_lane_mask << w_off) : 4'b0000;
    assign o_rd_data    = i_d_port >> {w_off, 3'b000};
    assign o_wr_data    = (w_cpu_shifted & w_port_mask) | (i_d_cpu & ~w_port_mask);

endmodule

// File: rtl/bus_sizer_sm.sv
// bus_sizer_sm: 68040 to Amiga-side dynamic bus sizing state machine.
// Optional bus timeout is compiled in with BUS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an off-board TS_CPUn
// SETUP | latch port width, compute sub-cycle count
// ISSUE | drive TSn low for one clock
// WAIT  | sample {TACKn,TEAn} each clock
// DONE  | TA to CPU; continue a burst or return to IDLE
module bus_sizer_sm
    import bus_sizer_pkg::*;
#(
    parameter int MAX_BURST = 4
`ifdef BUS_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        CLK40,
    input  logic        RESET,
    input  logic        TS_CPUn,
    input  logic        RnW,
    input  logic [1:0]  SIZ,
    input  logic [1:0]  A_040,
    input  logic        LBENn,
    input  logic [1:0]  PORTSIZE,
    input  logic        TACKn,
    input  logic        TEAn,
    input  logic        TBIn,
    input  logic [31:0] D_CPU_IN,
    input  logic [31:0] D_PORT_IN,
    output logic        TSn,
    output logic [1:0]  A_PORT,
    output logic [31:0] D_CPU_OUT,
    output logic [31:0] D_PORT_OUT,
    output logic        D_PORT_OE,
    output logic        TA_CPUn,
    output logic        TEA_CPUn,
    output logic        TBI_CPUn,
    output logic        BUSY
);

    localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
`endif

    state_e            r_state;
    logic              r_rnw, r_tsn, r_ta_n, r_tea_n, r_tbi_n, r_oe, r_busy;
    logic [1:0]        r_siz, r_a, r_portsize, r_a_port, r_k, r_last_k;
    logic [BEAT_W-1:0] r_beat;
    logic [31:0]       r_asm, r_d_cpu_out;

    logic [3:0]  w_rd_en;
    logic [31:0] w_rd_data;
    logic        w_ps32;
    term_e       w_term;

    assign w_term = term_e'({TACKn, TEAn});
    assign w_ps32 = (r_portsize == PS_32) || (r_portsize == PS_32_ALT);

    bus_lane_steer u_steer (
        .i_portsize   (r_portsize),
        .i_a_port     (r_a_port),
        .i_rnw        (r_rnw),
        .i_d_cpu      (D_CPU_IN),
        .i_d_port     (D_PORT_IN),
        .o_rd_lane_en (w_rd_en),
        .o_rd_data    (w_rd_data),
        .o_wr_data    (D_PORT_OUT)
    );

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_rnw       <= 1'b1;
            r_siz       <= SIZ_LONG;
            r_a         <= 2'd0;
            r_portsize  <= PS_32;
            r_a_port    <= 2'd0;
            r_k         <= 2'd0;
            r_last_k    <= 2'd0;
            r_beat      <= '0;
            r_asm       <= 32'd0;
            r_d_cpu_out <= 32'd0;
            r_tsn       <= 1'b1;
            r_ta_n      <= 1'b1;
            r_tea_n     <= 1'b1;
            r_tbi_n     <= 1'b1;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            // Strobes are single-clock pulses unless re-asserted below
            r_tsn   <= 1'b1;
            r_ta_n  <= 1'b1;
            r_tea_n <= 1'b1;
            r_tbi_n <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (!TS_CPUn && LBENn) begin
                        r_rnw   <= RnW;
                        r_siz   <= SIZ;
                        r_a     <= A_040;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_portsize <= PORTSIZE;
                    r_last_k   <= last_sub(r_siz, PORTSIZE);
                    r_k        <= 2'd0;
                    r_beat     <= '0;
                    r_a_port   <= r_a;
                    r_oe       <= !r_rnw;
                    r_state    <= ISSUE;
                end
                ISSUE: begin
                    r_tsn   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    case (w_term)
                        TERM_NORMAL: begin
                            for (int l = 0; l < 4; l++) begin
                                if (w_rd_en[l]) r_asm[31-8*l -: 8] <= w_rd_data[31-8*l -: 8];
                            end
                            if (r_k != r_last_k) begin
                                r_k      <= r_k + 2'd1;
                                r_a_port <= r_a_port + addr_step(r_portsize);
                                r_state  <= ISSUE;
                            end else begin
                                r_state <= DONE;
                            end
                        end
                        TERM_RETRY: begin
                            if (r_k == 2'd0) begin
                                r_ta_n  <= 1'b0;
                                r_tea_n <= 1'b0;
                                r_busy  <= 1'b0;
                                r_oe    <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_state <= ISSUE;
                            end
                        end
                        TERM_ERROR: begin
                            r_tea_n <= 1'b0;
                            r_busy  <= 1'b0;
                            r_oe    <= 1'b0;
                            r_state <= IDLE;
                        end
                        default: begin
`ifdef BUS_TIMEOUT_EN
                            if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                                r_tea_n <= 1'b0;
                                r_busy  <= 1'b0;
                                r_oe    <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_to_cnt <= r_to_cnt + 1'b1;
                            end
`endif
                        end
                    endcase
                end
                DONE: begin
                    r_ta_n      <= 1'b0;
                    r_d_cpu_out <= r_asm;
                    // Bursts continue only on a full-width port the target lets burst
                    if (r_siz == SIZ_LINE && w_ps32 && TBIn &&
                        r_beat != BEAT_W'(MAX_BURST - 1)) begin
                        r_beat  <= r_beat + 1'b1;
`ifdef BUS_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                        r_state <= WAIT;
                    end else begin
                        if (r_siz == SIZ_LINE && !(w_ps32 && TBIn)) r_tbi_n <= 1'b0;
                        r_busy  <= 1'b0;
                        r_oe    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign TSn       = r_tsn;
    assign A_PORT    = r_a_port;
    assign D_CPU_OUT = r_d_cpu_out;
    assign D_PORT_OE = r_oe;
    assign TA_CPUn   = r_ta_n;
    assign TEA_CPUn  = r_tea_n;
    assign TBI_CPUn  = r_tbi_n;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_bus_sizer_sm.sv
// tb_bus_sizer_sm: directed checks of the bus sizer (sizing, lanes, retry, error,
// bursts, reset abort, and the BUS_TIMEOUT_EN timeout when that macro is defined).
module tb_bus_sizer_sm;
    import bus_sizer_pkg::*;

    logic        CLK40, RESET, TS_CPUn, RnW, LBENn, TACKn, TEAn, TBIn;
    logic [1:0]  SIZ, A_040, PORTSIZE, A_PORT;
    logic [31:0] D_CPU_IN, D_PORT_IN, D_CPU_OUT, D_PORT_OUT;
    logic        TSn, D_PORT_OE, TA_CPUn, TEA_CPUn, TBI_CPUn, BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    bus_sizer_sm #(
        .MAX_BURST(4)
`ifdef BUS_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) u_dut (
        .CLK40(CLK40), .RESET(RESET), .TS_CPUn(TS_CPUn), .RnW(RnW), .SIZ(SIZ),
        .A_040(A_040), .LBENn(LBENn), .PORTSIZE(PORTSIZE), .TACKn(TACKn),
        .TEAn(TEAn), .TBIn(TBIn), .D_CPU_IN(D_CPU_IN), .D_PORT_IN(D_PORT_IN),
        .TSn(TSn), .A_PORT(A_PORT), .D_CPU_OUT(D_CPU_OUT), .D_PORT_OUT(D_PORT_OUT),
        .D_PORT_OE(D_PORT_OE), .TA_CPUn(TA_CPUn), .TEA_CPUn(TEA_CPUn),
        .TBI_CPUn(TBI_CPUn), .BUSY(BUSY)
    );

    initial begin
        CLK40 = 1'b0;
        forever #5 CLK40 = ~CLK40;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_start(input logic rnw, input logic [1:0] siz, input logic [1:0] a,
                             input logic [1:0] ps);
        RnW = rnw; SIZ = siz; A_040 = a; PORTSIZE = ps; TS_CPUn = 1'b0;
        tick();
        TS_CPUn = 1'b1;
    endtask

    // Waits (bounded) for TSn low; n is the number of clocks it took
    task automatic wait_ts(input string tag, output int n);
        n = 0;
        while (TSn !== 1'b0 && n < 16) begin
            tick();
            n++;
        end
        chk({tag, " tsn"}, 32'(TSn), 32'd0);
    endtask

    task automatic respond(input term_e term, input logic [31:0] dport);
        {TACKn, TEAn} = term;
        D_PORT_IN = dport;
        tick();
        {TACKn, TEAn} = TERM_WAIT;
    endtask

    initial begin
        int n, lows;
        logic [31:0] wr_exp [4];
        logic [31:0] beat_dat [4];
        wr_exp[0] = 32'hAABB_CCDD; wr_exp[1] = 32'hBBBB_CCDD;
        wr_exp[2] = 32'hCCBB_CCDD; wr_exp[3] = 32'hDDBB_CCDD;
        beat_dat[0] = 32'h0101_0101; beat_dat[1] = 32'h2323_2323;
        beat_dat[2] = 32'h4545_4545; beat_dat[3] = 32'h6767_6767;

        RESET = 1'b1; TS_CPUn = 1'b1; RnW = 1'b1; SIZ = SIZ_LONG; A_040 = 2'd0;
        LBENn = 1'b1; PORTSIZE = PS_32; {TACKn, TEAn} = TERM_WAIT; TBIn = 1'b1;
        D_CPU_IN = 32'd0; D_PORT_IN = 32'd0;
        tick(); tick();
        chk("rst tsn", 32'(TSn), 32'd1);
        chk("rst ta", 32'(TA_CPUn), 32'd1);
        chk("rst tea", 32'(TEA_CPUn), 32'd1);
        chk("rst tbi", 32'(TBI_CPUn), 32'd1);
        chk("rst busy_oe_aport", {28'd0, BUSY, D_PORT_OE, A_PORT}, 32'd0);
        chk("rst dcpu", D_CPU_OUT, 32'd0);
        RESET = 1'b0;
        tick();

        // Long read, 32-bit port, zero wait: exact edge timing
        cpu_start(1'b1, SIZ_LONG, 2'd0, PS_32);
        chk("t1 busy", 32'(BUSY), 32'd1);
        chk("t1 tsn e0", 32'(TSn), 32'd1);
        tick();
        chk("t1 tsn e1", 32'(TSn), 32'd1);
        tick();
        chk("t1 tsn e2", 32'(TSn), 32'd0);
        chk("t1 aport", 32'(A_PORT), 32'd0);
        respond(TERM_NORMAL, 32'h1234_5678);
        chk("t1 tsn e3", 32'(TSn), 32'd1);
        chk("t1 ta e3", 32'(TA_CPUn), 32'd1);
        tick();
        chk("t1 ta e4", 32'(TA_CPUn), 32'd0);
        chk("t1 dcpu", D_CPU_OUT, 32'h1234_5678);
        tick();
        chk("t1 ta e5", 32'(TA_CPUn), 32'd1);
        chk("t1 idle", 32'(BUSY), 32'd0);

        // Long read, 16-bit port: two sub-cycles, second TSn 2 clocks later
        cpu_start(1'b1, SIZ_LONG, 2'd0, PS_16);
        wait_ts("t2a", n);
        chk("t2a latency", n, 2);
        chk("t2a aport", 32'(A_PORT), 32'd0);
        respond(TERM_NORMAL, 32'h1234_AAAA);
        chk("t2 no early ta", 32'(TA_CPUn), 32'd1);
        wait_ts("t2b", n);
        chk("t2b gap", n, 1);
        chk("t2b aport", 32'(A_PORT), 32'd2);
        respond(TERM_NORMAL, 32'h5678_BBBB);
        tick();
        chk("t2 ta", 32'(TA_CPUn), 32'd0);
        chk("t2 tbi", 32'(TBI_CPUn), 32'd1);
        chk("t2 dcpu", D_CPU_OUT, 32'h1234_5678);
        tick();
        chk("t2 ta release", 32'(TA_CPUn), 32'd1);

        // Long write to 8-bit port
        D_CPU_IN = 32'hAABB_CCDD;
        cpu_start(1'b0, SIZ_LONG, 2'd0, PS_8);
        for (int k = 0; k < 4; k++) begin
            wait_ts($sformatf("t3 k%0d", k), n);
            chk($sformatf("t3 aport k%0d", k), 32'(A_PORT), 32'(k));
            chk($sformatf("t3 dout k%0d", k), D_PORT_OUT, wr_exp[k]);
            chk($sformatf("t3 oe k%0d", k), 32'(D_PORT_OE), 32'd1);
            respond(TERM_NORMAL, 32'd0);
        end
        tick();
        chk("t3 ta", 32'(TA_CPUn), 32'd0);
        chk("t3 oe off", 32'(D_PORT_OE), 32'd0);
        tick();

        // Byte read at A=3 from a 16-bit port
        cpu_start(1'b1, SIZ_BYTE, 2'd3, PS_16);
        wait_ts("t4", n);
        chk("t4 aport", 32'(A_PORT), 32'd3);
        respond(TERM_NORMAL, 32'h5A5A_0000);
        tick();
        chk("t4 ta", 32'(TA_CPUn), 32'd0);
        chk("t4 byte", 32'(D_CPU_OUT[7:0]), 32'h5A);
        tick();

        // Retry on second sub-cycle: same sub-cycle re-issued
        cpu_start(1'b1, SIZ_LONG, 2'd0, PS_16);
        wait_ts("t5a", n);
        respond(TERM_NORMAL, 32'h1111_0000);
        wait_ts("t5b", n);
        respond(TERM_RETRY, 32'hDEAD_0000);
        chk("t5 retry hidden ta", 32'(TA_CPUn), 32'd1);
        chk("t5 retry hidden tea", 32'(TEA_CPUn), 32'd1);
        wait_ts("t5c", n);
        chk("t5c aport", 32'(A_PORT), 32'd2);
        respond(TERM_NORMAL, 32'h2222_0000);
        tick();
        chk("t5 ta", 32'(TA_CPUn), 32'd0);
        chk("t5 tea", 32'(TEA_CPUn), 32'd1);
        chk("t5 dcpu", D_CPU_OUT, 32'h1111_2222);
        tick();

        // Retry on first sub-cycle goes straight back to the CPU
        cpu_start(1'b1, SIZ_LONG, 2'd0, PS_16);
        wait_ts("t6", n);
        respond(TERM_RETRY, 32'd0);
        chk("t6 ta", 32'(TA_CPUn), 32'd0);
        chk("t6 tea", 32'(TEA_CPUn), 32'd0);
        chk("t6 busy", 32'(BUSY), 32'd0);
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (TSn === 1'b0) lows++;
        end
        chk("t6 no more tsn", lows, 0);
        chk("t6 ta release", 32'(TA_CPUn), 32'd1);

        // Bus error: TEA only, data discarded
        cpu_start(1'b1, SIZ_LONG, 2'd0, PS_32);
        wait_ts("t7", n);
        respond(TERM_ERROR, 32'hBAD0_BAD0);
        chk("t7 tea", 32'(TEA_CPUn), 32'd0);
        chk("t7 ta", 32'(TA_CPUn), 32'd1);
        tick();
        chk("t7 tea release", 32'(TEA_CPUn), 32'd1);
        chk("t7 busy", 32'(BUSY), 32'd0);
        chk("t7 dcpu kept", D_CPU_OUT, 32'h1111_2222);

        // Line burst on 32-bit port, TBIn=1: one TSn, four TA beats
        TBIn = 1'b1;
        cpu_start(1'b1, SIZ_LINE, 2'd0, PS_32);
        wait_ts("t8", n);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) chk($sformatf("t8 no tsn b%0d", b), 32'(TSn), 32'd1);
            respond(TERM_NORMAL, beat_dat[b]);
            tick();
            chk($sformatf("t8 ta b%0d", b), 32'(TA_CPUn), 32'd0);
            chk($sformatf("t8 tbi b%0d", b), 32'(TBI_CPUn), 32'd1);
            chk($sformatf("t8 data b%0d", b), D_CPU_OUT, beat_dat[b]);
        end
        chk("t8 busy end", 32'(BUSY), 32'd0);
        tick();

        // Line with TBIn=0: burst inhibited on the first TA
        TBIn = 1'b0;
        cpu_start(1'b1, SIZ_LINE, 2'd0, PS_32);
        wait_ts("t9", n);
        respond(TERM_NORMAL, 32'hCAFE_F00D);
        tick();
        chk("t9 ta", 32'(TA_CPUn), 32'd0);
        chk("t9 tbi", 32'(TBI_CPUn), 32'd0);
        chk("t9 busy", 32'(BUSY), 32'd0);
        tick();
        chk("t9 tbi release", 32'(TBI_CPUn), 32'd1);
        TBIn = 1'b1;

        // On-board cycle is ignored
        LBENn = 1'b0; TS_CPUn = 1'b0;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (TSn === 1'b0 || BUSY === 1'b1) lows++;
        end
        chk("t10 onboard idle", lows, 0);
        TS_CPUn = 1'b1; LBENn = 1'b1;
        tick();

        // Reset mid-cycle aborts without termination
        cpu_start(1'b1, SIZ_LONG, 2'd1, PS_8);
        wait_ts("t11", n);
        RESET = 1'b1;
        {TACKn, TEAn} = TERM_NORMAL;
        tick();
        RESET = 1'b0;
        chk("t11 busy", 32'(BUSY), 32'd0);
        chk("t11 aport dcpu", {A_PORT, D_CPU_OUT[29:0]}, 32'd0);
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (TA_CPUn === 1'b0 || TEA_CPUn === 1'b0 || TSn === 1'b0) lows++;
        end
        chk("t11 no term", lows, 0);
        {TACKn, TEAn} = TERM_WAIT;
        tick();

`ifdef BUS_TIMEOUT_EN
        // No termination: TEA 8 clocks after entering WAIT
        cpu_start(1'b1, SIZ_LONG, 2'd0, PS_32);
        wait_ts("t12", n);
        lows = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (TEA_CPUn === 1'b0) lows++;
        end
        chk("t12 no early tea", lows, 0);
        tick();
        chk("t12 tea", 32'(TEA_CPUn), 32'd0);
        chk("t12 tsn", 32'(TSn), 32'd1);
        chk("t12 busy", 32'(BUSY), 32'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
